// File: rtl/mandelbrot_iter_engine.sv
// Fixed-point Mandelbrot escape-time engine: iterates Z <= Z^2 + C for one point per start.
// Define MANDEL_JULIA_EN to add the Julia-set inputs (julia, jr_in, ji_in).
module mandelbrot_iter_engine #(
  parameter int WIDTH  = 16,
  parameter int FRAC   = 12,
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  cr_in,
  input  logic [WIDTH-1:0]  ci_in,
`ifdef MANDEL_JULIA_EN
  input  logic              julia,
  input  logic [WIDTH-1:0]  jr_in,
  input  logic [WIDTH-1:0]  ji_in,
`endif
  input  logic [ITER_W-1:0] max_iter,
  output logic              busy,
  output logic              done,
  output logic              escaped,
  output logic [ITER_W-1:0] iter_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // 4.0 expressed in the 2*FRAC fractional format of a full product
  localparam logic [2*WIDTH:0] FOUR_FIX = (2*WIDTH+1)'(3'd4) << (2*FRAC);

  state_t                    state_q, state_d;
  logic signed [WIDTH-1:0]   zr_q, zr_d, zi_q, zi_d;
  logic signed [WIDTH-1:0]   cr_q, cr_d, ci_q, ci_d;
  logic        [ITER_W-1:0]  k_q, k_d, max_q, max_d, cnt_q, cnt_d;
  logic                      esc_q, esc_d, busy_q, busy_d, done_q, done_d;

  logic signed [2*WIDTH-1:0] zr_sq_s, zi_sq_s, zri_s;
  logic signed [2*WIDTH:0]   zri2_s;
  logic        [2*WIDTH:0]   mag_s;
  logic                      escape_s;
  logic signed [WIDTH-1:0]   zr_upd_s, zi_upd_s;

  // Datapath: full-width products, guarded magnitude compare, wrapping updates
  always_comb begin
    zr_sq_s  = zr_q * zr_q;
    zi_sq_s  = zi_q * zi_q;
    zri_s    = zr_q * zi_q;
    zri2_s   = {zri_s, 1'b0};
    // Squares are non-negative, so a zero guard bit keeps the sum from wrapping
    mag_s    = {1'b0, zr_sq_s} + {1'b0, zi_sq_s};
    escape_s = (mag_s > FOUR_FIX);
    zr_upd_s = WIDTH'(zr_sq_s >>> FRAC) - WIDTH'(zi_sq_s >>> FRAC) + cr_q;
    zi_upd_s = WIDTH'(zri2_s >>> FRAC) + ci_q;
  end

  // Next-state and next-register logic
  always_comb begin
    state_d = state_q;
    zr_d    = zr_q;
    zi_d    = zi_q;
    cr_d    = cr_q;
    ci_d    = ci_q;
    k_d     = k_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    esc_d   = esc_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_ITER;
          k_d     = {ITER_W{1'b0}};
          max_d   = max_iter;
          cnt_d   = {ITER_W{1'b0}};
          esc_d   = 1'b0;
`ifdef MANDEL_JULIA_EN
          if (julia) begin
            zr_d = cr_in;
            zi_d = ci_in;
            cr_d = jr_in;
            ci_d = ji_in;
          end else begin
            zr_d = {WIDTH{1'b0}};
            zi_d = {WIDTH{1'b0}};
            cr_d = cr_in;
            ci_d = ci_in;
          end
`else
          zr_d = {WIDTH{1'b0}};
          zi_d = {WIDTH{1'b0}};
          cr_d = cr_in;
          ci_d = ci_in;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ITER: begin
        if (escape_s) begin
          esc_d   = 1'b1;
          cnt_d   = k_q;
          state_d = ST_DONE;
        end else if (k_q == max_q) begin
          esc_d   = 1'b0;
          cnt_d   = max_q;
          state_d = ST_DONE;
        end else begin
          zr_d = zr_upd_s;
          zi_d = zi_upd_s;
          k_d  = k_q + ITER_W'(1'b1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_ITER);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      zr_q    <= {WIDTH{1'b0}};
      zi_q    <= {WIDTH{1'b0}};
      cr_q    <= {WIDTH{1'b0}};
      ci_q    <= {WIDTH{1'b0}};
      k_q     <= {ITER_W{1'b0}};
      max_q   <= {ITER_W{1'b0}};
      cnt_q   <= {ITER_W{1'b0}};
      esc_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      zr_q    <= zr_d;
      zi_q    <= zi_d;
      cr_q    <= cr_d;
      ci_q    <= ci_d;
      k_q     <= k_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
      esc_q   <= esc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign escaped    = esc_q;
  assign iter_count = cnt_q;

endmodule

// File: tb/tb_mandelbrot_iter_engine.sv
// Self-checking bench for mandelbrot_iter_engine (WIDTH=16, FRAC=12, ITER_W=8).
// Compiles the Julia-mode scenario only when MANDEL_JULIA_EN is defined.
module tb_mandelbrot_iter_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] cr_in, ci_in;
  logic        julia;
  logic [15:0] jr_in, ji_in;
  logic [7:0]  max_iter;
  logic        busy, done, escaped;
  logic [7:0]  iter_count;

  int n_pass  = 0;
  int n_total = 0;

  mandelbrot_iter_engine #(.WIDTH(16), .FRAC(12), .ITER_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cr_in(cr_in), .ci_in(ci_in),
`ifdef MANDEL_JULIA_EN
    .julia(julia), .jr_in(jr_in), .ji_in(ji_in),
`endif
    .max_iter(max_iter), .busy(busy), .done(done),
    .escaped(escaped), .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  function automatic longint wrap16(input longint v);
    shortint s;
    s = shortint'(v);
    return longint'(s);
  endfunction

  // Escape-time reference: real-valued recurrence scaled by 4096, floor products, 16-bit wrap
  function automatic void model(input logic [15:0] z0r, input logic [15:0] z0i,
                                input logic [15:0] c_r, input logic [15:0] c_i,
                                input logic [7:0] mi, output logic esc, output logic [7:0] cnt);
    longint zr, zi, cr, ci, nzr, nzi;
    longint four;
    four = 64'sd4 * 64'sd4096 * 64'sd4096;
    zr = longint'($signed(z0r));
    zi = longint'($signed(z0i));
    cr = longint'($signed(c_r));
    ci = longint'($signed(c_i));
    esc = 1'b0;
    cnt = mi;
    for (int k = 0; k <= int'(mi); k++) begin
      if (zr * zr + zi * zi > four) begin
        esc = 1'b1;
        cnt = 8'(k);
        return;
      end
      if (k == int'(mi)) return;
      nzr = wrap16(((zr * zr) >>> 12) - ((zi * zi) >>> 12) + cr);
      nzi = wrap16(((64'sd2 * zr * zi) >>> 12) + ci);
      zr = nzr;
      zi = nzi;
    end
  endfunction

  // Starts one point (caller is at posedge+1 in IDLE/DONE) and measures the result
  task automatic run_point(input logic [15:0] cr, input logic [15:0] ci, input logic [7:0] mi,
                           input logic jul, input logic [15:0] jr, input logic [15:0] ji,
                           output int edges, output logic esc_o, output logic [7:0] cnt_o,
                           output logic busy_o, output logic done_after_o,
                           output logic esc_hold_o, output logic [7:0] cnt_hold_o);
    cr_in = cr; ci_in = ci; max_iter = mi; julia = jul; jr_in = jr; ji_in = ji;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_o = busy;
    edges = -1;
    for (int e = 1; e <= 300; e++) begin
      @(posedge clk); #1;
      if (done) begin
        edges = e;
        break;
      end
    end
    esc_o = escaped;
    cnt_o = iter_count;
    @(posedge clk); #1;
    done_after_o = done;
    esc_hold_o = escaped;
    cnt_hold_o = iter_count;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; cr_in = 16'h0000; ci_in = 16'h0000;
    max_iter = 8'd0; julia = 1'b0; jr_in = 16'h0000; ji_in = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_total++; if (escaped !== 1'b0) $display("FAIL reset_escaped got %b want 0", escaped); else n_pass++;
    n_total++; if (iter_count !== 8'd0) $display("FAIL reset_iter_count got %0d want 0", iter_count); else n_pass++;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL post_reset_idle_busy got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL post_reset_idle_done got %b want 0", done); else n_pass++;
  endtask

  task automatic test_directed();
    logic [15:0] cr_t [4] = '{16'h0000, 16'h2800, 16'hE000, 16'h0000};
    logic [7:0]  mi_t [4] = '{8'd10, 8'd20, 8'd15, 8'd0};
    int          ed_t [4] = '{11, 2, 16, 1};
    logic        es_t [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0]  ct_t [4] = '{8'd10, 8'd1, 8'd15, 8'd0};
    int edges; logic esc, bsy, dna, esh; logic [7:0] cnt, cnh;
    for (int i = 0; i < 4; i++) begin
      run_point(cr_t[i], 16'h0000, mi_t[i], 1'b0, 16'h0000, 16'h0000,
                edges, esc, cnt, bsy, dna, esh, cnh);
      n_total++; if (edges != ed_t[i]) $display("FAIL dir%0d_latency got %0d want %0d", i, edges, ed_t[i]); else n_pass++;
      n_total++; if (esc !== es_t[i]) $display("FAIL dir%0d_escaped got %b want %b", i, esc, es_t[i]); else n_pass++;
      n_total++; if (cnt !== ct_t[i]) $display("FAIL dir%0d_iter_count got %0d want %0d", i, cnt, ct_t[i]); else n_pass++;
      n_total++; if (bsy !== 1'b1) $display("FAIL dir%0d_busy got %b want 1", i, bsy); else n_pass++;
      n_total++; if (dna !== 1'b0) $display("FAIL dir%0d_done_pulse got %b want 0", i, dna); else n_pass++;
      n_total++; if (esh !== es_t[i] || cnh !== ct_t[i])
        $display("FAIL dir%0d_hold got %b/%0d want %b/%0d", i, esh, cnh, es_t[i], ct_t[i]); else n_pass++;
    end
  endtask

  task automatic test_random();
    int edges; logic esc, bsy, dna, esh, m_esc; logic [7:0] cnt, cnh, m_cnt, mi;
    logic [15:0] cr, ci;
    for (int i = 0; i < 30; i++) begin
      if (i % 5 == 4) begin
        cr = 16'($urandom);
        ci = 16'($urandom);
      end else begin
        cr = 16'($urandom_range(0, 14335) - 10240);
        ci = 16'($urandom_range(0, 12288) - 6144);
      end
      mi = 8'($urandom_range(0, 40));
      model(16'h0000, 16'h0000, cr, ci, mi, m_esc, m_cnt);
      run_point(cr, ci, mi, 1'b0, 16'h0000, 16'h0000, edges, esc, cnt, bsy, dna, esh, cnh);
      n_total++;
      if (edges != int'(m_cnt) + 1 || esc !== m_esc || cnt !== m_cnt || dna !== 1'b0)
        $display("FAIL rand%0d C=(%h,%h) max=%0d got lat=%0d esc=%b cnt=%0d dn=%b want lat=%0d esc=%b cnt=%0d dn=0",
                 i, cr, ci, mi, edges, esc, cnt, dna, int'(m_cnt) + 1, m_esc, m_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_ignore_start();
    int edges = -1; logic bsy;
    cr_in = 16'h0000; ci_in = 16'h0000; max_iter = 8'd12; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cr_in = 16'h2800; max_iter = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bsy = busy;
    for (int e = 5; e <= 300; e++) begin
      @(posedge clk); #1;
      if (done) begin
        edges = e;
        break;
      end
    end
    n_total++; if (bsy !== 1'b1) $display("FAIL ignore_busy got %b want 1", bsy); else n_pass++;
    n_total++; if (edges != 13) $display("FAIL ignore_latency got %0d want 13", edges); else n_pass++;
    n_total++; if (escaped !== 1'b0 || iter_count !== 8'd12)
      $display("FAIL ignore_result got %b/%0d want 0/12", escaped, iter_count); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int edges = -1;
    cr_in = 16'h2800; ci_in = 16'h0000; max_iter = 8'd20; start = 1'b1;
    @(posedge clk); #1;
    cr_in = 16'h0000; max_iter = 8'd5;
    for (int e = 1; e <= 300; e++) begin
      @(posedge clk); #1;
      if (done) begin
        edges = e;
        break;
      end
    end
    n_total++; if (edges != 2 || escaped !== 1'b1 || iter_count !== 8'd1)
      $display("FAIL b2b_first got lat=%0d %b/%0d want lat=2 1/1", edges, escaped, iter_count); else n_pass++;
    @(posedge clk); #1;
    start = 1'b0;
    n_total++; if (done !== 1'b0 || busy !== 1'b1)
      $display("FAIL b2b_accept got done=%b busy=%b want 0/1", done, busy); else n_pass++;
    edges = -1;
    for (int e = 1; e <= 300; e++) begin
      @(posedge clk); #1;
      if (done) begin
        edges = e;
        break;
      end
    end
    n_total++; if (edges != 6 || escaped !== 1'b0 || iter_count !== 8'd5)
      $display("FAIL b2b_second got lat=%0d %b/%0d want lat=6 0/5", edges, escaped, iter_count); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int edges, seen; logic esc, bsy, dna, esh; logic [7:0] cnt, cnh;
    run_point(16'h2800, 16'h0000, 8'd20, 1'b0, 16'h0000, 16'h0000, edges, esc, cnt, bsy, dna, esh, cnh);
    #3 rst_n = 1'b0;
    #1;
    n_total++; if (escaped !== 1'b0 || iter_count !== 8'd0)
      $display("FAIL rst_idle_outputs got %b/%0d want 0/0", escaped, iter_count); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cr_in = 16'h0000; ci_in = 16'h0000; max_iter = 8'd50; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0 || done !== 1'b0 || escaped !== 1'b0 || iter_count !== 8'd0)
      $display("FAIL rst_mid got busy=%b done=%b esc=%b cnt=%0d want all 0", busy, done, escaped, iter_count); else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int e = 0; e < 60; e++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    n_total++; if (seen != 0) $display("FAIL rst_no_done got %0d active cycles want 0", seen); else n_pass++;
    run_point(16'h0000, 16'h0000, 8'd3, 1'b0, 16'h0000, 16'h0000, edges, esc, cnt, bsy, dna, esh, cnh);
    n_total++; if (edges != 4 || esc !== 1'b0 || cnt !== 8'd3)
      $display("FAIL rst_recover got lat=%0d %b/%0d want lat=4 0/3", edges, esc, cnt); else n_pass++;
  endtask

`ifdef MANDEL_JULIA_EN
  task automatic test_julia();
    int edges; logic esc, bsy, dna, esh, m_esc; logic [7:0] cnt, cnh, m_cnt, mi;
    logic [15:0] zr, zi, jr, ji;
    run_point(16'h3000, 16'h0000, 8'd20, 1'b1, 16'h0000, 16'h0000, edges, esc, cnt, bsy, dna, esh, cnh);
    n_total++; if (edges != 1 || esc !== 1'b1 || cnt !== 8'd0)
      $display("FAIL julia_dir got lat=%0d %b/%0d want lat=1 1/0", edges, esc, cnt); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      zr = 16'($urandom_range(0, 12288) - 6144);
      zi = 16'($urandom_range(0, 12288) - 6144);
      jr = 16'($urandom_range(0, 8192) - 4096);
      ji = 16'($urandom_range(0, 8192) - 4096);
      mi = 8'($urandom_range(0, 30));
      model(zr, zi, jr, ji, mi, m_esc, m_cnt);
      run_point(zr, zi, mi, 1'b1, jr, ji, edges, esc, cnt, bsy, dna, esh, cnh);
      n_total++;
      if (edges != int'(m_cnt) + 1 || esc !== m_esc || cnt !== m_cnt)
        $display("FAIL julia%0d got lat=%0d %b/%0d want lat=%0d %b/%0d",
                 i, edges, esc, cnt, int'(m_cnt) + 1, m_esc, m_cnt);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
`ifdef MANDEL_JULIA_EN
    test_julia();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
